// File: rtl/eth_rx_frame_writer.sv
// RMII receive frame writer: hunts preamble/SFD, packs LSB-first dibits into bytes and writes them to RAM.
// Optional running CRC-32 residue check is enabled by defining ETH_RX_CRC_CHECK_EN.
module eth_rx_frame_writer #(
  parameter int RAM_SIZE       = 2048,
  parameter int MAX_FRAME_LEN  = 1522,
  parameter int MIN_PRE_DIBITS = 8,
  localparam int AW            = $clog2(RAM_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic [AW-1:0] base_addr,
  input  logic          inclk,
  input  logic [1:0]    in,
  input  logic          done_in,
  output logic          write_req,
  output logic [AW-1:0] write_addr,
  output logic [7:0]    write_val,
  output logic          busy,
  output logic          frame_done,
  output logic [10:0]   frame_len,
  output logic [2:0]    frame_err
);

  localparam int            PW      = $clog2(MIN_PRE_DIBITS + 1);
  localparam logic [PW-1:0] PRE_MIN = PW'(MIN_PRE_DIBITS);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);
  localparam logic [10:0]   MAX_LEN = 11'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_PRE  = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] base_r;
  logic [10:0]   byte_cnt_r, byte_cnt_s;
  logic [PW-1:0] pre_cnt_r, pre_cnt_s;
  logic [1:0]    dibit_idx_r, dibit_idx_s;
  logic [7:0]    shift_r, shift_s, byte_s;
  logic          arm_ok_s, wr_s, ovf_s, done_s, crc_bad_s;
  logic [AW-1:0] wr_addr_s;
  logic [7:0]    wr_val_s;

  logic          write_req_r, busy_r, frame_done_r;
  logic [AW-1:0] write_addr_r;
  logic [7:0]    write_val_r;
  logic [10:0]   frame_len_r;
  logic [2:0]    frame_err_r;

  // Next-state, byte assembly and write scheduling
  always_comb begin
    state_s     = state_r;
    pre_cnt_s   = pre_cnt_r;
    dibit_idx_s = dibit_idx_r;
    shift_s     = shift_r;
    byte_cnt_s  = byte_cnt_r;
    byte_s      = {in, shift_r[7:2]};
    arm_ok_s    = 1'b0;
    wr_s        = 1'b0;
    wr_addr_s   = write_addr_r;
    wr_val_s    = write_val_r;
    ovf_s       = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          arm_ok_s   = 1'b1;
          state_s    = ST_HUNT;
          byte_cnt_s = 11'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HUNT: begin
        if (done_in) begin
          state_s = ST_HUNT;
        end else if (inclk && (in == 2'b01)) begin
          state_s   = ST_PRE;
          pre_cnt_s = PRE_ONE;
        end else begin
          state_s = ST_HUNT;
        end
      end
      ST_PRE: begin
        if (done_in) begin
          state_s = ST_HUNT;
        end else if (inclk) begin
          if (in == 2'b01) begin
            if (pre_cnt_r < PRE_MIN) begin
              pre_cnt_s = pre_cnt_r + PRE_ONE;
            end else begin
              pre_cnt_s = pre_cnt_r;
            end
          end else if ((in == 2'b11) && (pre_cnt_r >= PRE_MIN)) begin
            state_s     = ST_DATA;
            dibit_idx_s = 2'd0;
          end else begin
            state_s = ST_HUNT;
          end
        end else begin
          state_s = ST_PRE;
        end
      end
      ST_DATA: begin
        // A dibit arriving with done_in is folded in before the frame closes
        if (inclk) begin
          shift_s     = byte_s;
          dibit_idx_s = dibit_idx_r + 2'd1;
          if (dibit_idx_r == 2'd3) begin
            if (byte_cnt_r == MAX_LEN) begin
              ovf_s = 1'b1;
            end else begin
              wr_s       = 1'b1;
              wr_addr_s  = base_r + AW'(byte_cnt_r);
              wr_val_s   = byte_s;
              byte_cnt_s = byte_cnt_r + 11'd1;
            end
          end else begin
            ovf_s = 1'b0;
          end
        end else begin
          shift_s = shift_r;
        end
        if (done_in) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DATA;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc_r, crc_next_s;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Residue check includes a byte written in the same cycle the frame closes
  always_comb begin
    crc_next_s = crc_r;
    if (wr_s) begin
      crc_next_s = crc32_byte(crc_r, wr_val_s);
    end else begin
      crc_next_s = crc_r;
    end
    crc_bad_s = frame_err_r[0] | ovf_s | (crc_next_s != 32'hDEBB20E3);
  end

  // Running CRC over stored bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_r <= 32'hFFFFFFFF;
    end else if (arm_ok_s) begin
      crc_r <= 32'hFFFFFFFF;
    end else if (wr_s) begin
      crc_r <= crc_next_s;
    end
  end
`else
  assign crc_bad_s = 1'b0;
`endif

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      base_r       <= '0;
      byte_cnt_r   <= 11'd0;
      pre_cnt_r    <= '0;
      dibit_idx_r  <= 2'd0;
      shift_r      <= 8'h00;
      write_req_r  <= 1'b0;
      write_addr_r <= '0;
      write_val_r  <= 8'h00;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      frame_len_r  <= 11'd0;
      frame_err_r  <= 3'b000;
    end else begin
      state_r      <= state_s;
      byte_cnt_r   <= byte_cnt_s;
      pre_cnt_r    <= pre_cnt_s;
      dibit_idx_r  <= dibit_idx_s;
      shift_r      <= shift_s;
      write_req_r  <= wr_s;
      write_addr_r <= wr_addr_s;
      write_val_r  <= wr_val_s;
      busy_r       <= (state_s != ST_IDLE);
      frame_done_r <= done_s;
      if (arm_ok_s) begin
        base_r      <= base_addr;
        frame_len_r <= 11'd0;
        frame_err_r <= 3'b000;
      end else if (done_s) begin
        frame_len_r <= byte_cnt_s;
        frame_err_r <= {crc_bad_s, (dibit_idx_s != 2'd0), frame_err_r[0] | ovf_s};
      end else if (ovf_s) begin
        frame_err_r[0] <= 1'b1;
      end
    end
  end

  assign write_req  = write_req_r;
  assign write_addr = write_addr_r;
  assign write_val  = write_val_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign frame_len  = frame_len_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Bench for eth_rx_frame_writer: table of frames plus hand sequences, scoreboard queues for writes and frame status.
module tb_eth_rx_frame_writer;

  localparam int MAXL = 1522;
`ifdef ETH_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, arm, inclk, done_in;
  logic [10:0] base_addr;
  logic [1:0]  din;
  logic        write_req, busy, frame_done;
  logic [10:0] write_addr, frame_len;
  logic [7:0]  write_val;
  logic [2:0]  frame_err;

  eth_rx_frame_writer dut (
    .clk(clk), .reset(reset), .arm(arm), .base_addr(base_addr),
    .inclk(inclk), .in(din), .done_in(done_in),
    .write_req(write_req), .write_addr(write_addr), .write_val(write_val),
    .busy(busy), .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  typedef struct { logic [10:0] addr; logic [7:0] val; } wr_t;
  typedef struct { logic [10:0] len; logic [2:0] err; } fr_t;
  typedef struct {
    logic [10:0] base; int nbytes; int kind; int extra; bit dwl;
    logic [10:0] exp_len; logic [1:0] exp_err;
  } vec_t;

  wr_t        exp_wr_q[$];
  fr_t        exp_fr_q[$];
  logic [7:0] frame_q[$];
  vec_t       vecs[8];
  wr_t        mon_wr;
  fr_t        mon_fr;
  int checks = 0, errors = 0, done_cnt = 0, wr_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Scoreboard: compare every write and every frame_done against queued expectations
  always @(negedge clk) begin
    if (write_req === 1'b1) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h val %0h expected none", write_addr, write_val);
      end else begin
        mon_wr = exp_wr_q.pop_front();
        check("write_addr", 32'(write_addr), 32'(mon_wr.addr));
        check("write_val", 32'(write_val), 32'(mon_wr.val));
      end
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (exp_fr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_done: got len %0d expected none", frame_len);
      end else begin
        mon_fr = exp_fr_q.pop_front();
        check("frame_len", 32'(frame_len), 32'(mon_fr.len));
        check("frame_err", 32'(frame_err), 32'(mon_fr.err));
      end
    end
  end

  task automatic send_dibit(input logic [1:0] d, input bit with_done);
    @(posedge clk); #1;
    inclk = 1'b1; din = d; done_in = with_done;
    @(posedge clk); #1;
    inclk = 1'b0; done_in = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done_in = 1'b1;
    @(posedge clk); #1 done_in = 1'b0;
  endtask

  task automatic do_arm(input logic [10:0] b);
    @(posedge clk); #1 arm = 1'b1; base_addr = b;
    @(posedge clk); #1 arm = 1'b0;
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 8; i++) send_dibit(2'b01, 1'b0);
    send_dibit(2'b11, 1'b0);
  endtask

  task automatic build(input int kind, input int n);
    logic [31:0] c;
    frame_q.delete();
    if (kind == 0) begin
      frame_q.push_back(8'hAA); frame_q.push_back(8'h55); frame_q.push_back(8'h0F);
    end else if (kind == 3) begin
      for (int i = 0; i < n; i++) frame_q.push_back(8'(i) ^ 8'h5A);
    end else begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n - 4; i++) begin
        frame_q.push_back(8'($urandom_range(0, 255)));
        c = crc_upd(c, frame_q[i]);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) frame_q.push_back(c[8*k +: 8]);
      if (kind == 2) frame_q[10] = frame_q[10] ^ 8'h08;
    end
  endtask

  task automatic expect_frame(input logic [10:0] base, input logic [10:0] len, input logic [1:0] e10);
    logic [31:0] c;
    wr_t w;
    fr_t f;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i < MAXL) begin
        w.addr = base + 11'(i);
        w.val  = frame_q[i];
        exp_wr_q.push_back(w);
        c = crc_upd(c, frame_q[i]);
      end
    end
    f.len = len;
    f.err = {CRC_ON && ((frame_q.size() > MAXL) || (c != 32'hDEBB20E3)), e10};
    exp_fr_q.push_back(f);
  endtask

  task automatic send_bytes(input int extra, input bit dwl);
    logic [7:0] b;
    int n;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      b = frame_q[i];
      for (int k = 0; k < 4; k++)
        send_dibit(b[2*k +: 2], dwl && (extra == 0) && (i == n - 1) && (k == 3));
    end
    for (int e = 0; e < extra; e++) send_dibit(2'b10, dwl && (e == extra - 1));
    if (!dwl) pulse_done();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (((exp_wr_q.size() + exp_fr_q.size()) != 0) && (t < 50)) begin
      @(posedge clk); t++;
    end
    check("drain_outstanding", 32'(exp_wr_q.size() + exp_fr_q.size()), 32'd0);
    exp_wr_q.delete();
    exp_fr_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    wr_t w;
    reset = 1'b1; arm = 1'b0; inclk = 1'b0; done_in = 1'b0; din = 2'b00; base_addr = 11'd0;

    vecs[0] = '{11'h100, 3,    0, 0, 1'b0, 11'd3,    2'b00};
    vecs[1] = '{11'h000, 64,   1, 0, 1'b0, 11'd64,   2'b00};
    vecs[2] = '{11'h000, 64,   2, 0, 1'b0, 11'd64,   2'b00};
    vecs[3] = '{11'd2046, 4,   3, 0, 1'b0, 11'd4,    2'b00};
    vecs[4] = '{11'h200, 1600, 3, 0, 1'b0, 11'd1522, 2'b01};
    vecs[5] = '{11'h300, 3,    3, 2, 1'b0, 11'd3,    2'b10};
    vecs[6] = '{11'h400, 5,    3, 0, 1'b1, 11'd5,    2'b00};
    vecs[7] = '{11'h7F0, 20,   1, 1, 1'b1, 11'd20,   2'b10};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write_req", 32'(write_req), 32'd0);
    check("rst_write_addr", 32'(write_addr), 32'd0);
    check("rst_write_val", 32'(write_val), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      build(vecs[v].kind, vecs[v].nbytes);
      w0 = wr_cnt;
      do_arm(vecs[v].base);
      expect_frame(vecs[v].base, vecs[v].exp_len, vecs[v].exp_err);
      send_preamble();
      send_bytes(vecs[v].extra, vecs[v].dwl);
      drain();
      check("busy_after_frame", 32'(busy), 32'd0);
      check("write_count", 32'(wr_cnt - w0), 32'(vecs[v].exp_len));
      check("frame_len_hold", 32'(frame_len), 32'(vecs[v].exp_len));
    end

    // Inputs in IDLE are ignored
    w0 = wr_cnt; d0 = done_cnt;
    send_preamble();
    send_dibit(2'b10, 1'b0);
    pulse_done();
    repeat (3) @(posedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_writes", 32'(wr_cnt - w0), 32'd0);
    check("idle_done", 32'(done_cnt - d0), 32'd0);

    // Noise then done keeps hunting; a second arm while busy is ignored
    d0 = done_cnt;
    do_arm(11'h500);
    send_dibit(2'b01, 1'b0); send_dibit(2'b01, 1'b0); send_dibit(2'b10, 1'b0);
    pulse_done();
    repeat (3) @(posedge clk);
    check("noise_no_done", 32'(done_cnt - d0), 32'd0);
    check("noise_busy", 32'(busy), 32'd1);
    do_arm(11'h600);
    build(3, 6);
    expect_frame(11'h500, 11'd6, 2'b00);
    send_preamble();
    send_bytes(0, 1'b0);
    drain();

    // Reset in the middle of DATA aborts the capture
    w0 = wr_cnt; d0 = done_cnt;
    do_arm(11'h100);
    send_preamble();
    w.addr = 11'h100; w.val = 8'h3C;
    exp_wr_q.push_back(w);
    send_dibit(2'b00, 1'b0); send_dibit(2'b11, 1'b0); send_dibit(2'b11, 1'b0); send_dibit(2'b00, 1'b0);
    send_dibit(2'b01, 1'b0); send_dibit(2'b10, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) send_dibit(2'b11, 1'b0);
    pulse_done();
    repeat (4) @(posedge clk);
    drain();
    check("rstmid_writes", 32'(wr_cnt - w0), 32'd1);
    check("rstmid_done", 32'(done_cnt - d0), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_frame_len", 32'(frame_len), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
